// File: rtl/imu_sample_packer_if.sv
// Byte-stream input and scaled-sample output bundle for imu_sample_packer.
// The packer connects through the slave modport; the byte source and the
// filter side connect through the master modport.
interface imu_sample_packer_if #(
    parameter int ACC_WIDTH  = 11,
    parameter int GYRO_WIDTH = 14
);
    // Byte stream from the SPI burst-read engine
    logic                         frame_start;
    logic                         byte_valid;
    logic                         byte_ready;
    logic [7:0]                   byte_data;

    // Scaled sample toward the filter input handshake
    logic                         valid_out;
    logic                         ready_out;
    logic signed [ACC_WIDTH-1:0]  a_x;
    logic signed [ACC_WIDTH-1:0]  a_y;
    logic signed [ACC_WIDTH-1:0]  a_z;
    logic signed [GYRO_WIDTH-1:0] w_x;
    logic signed [GYRO_WIDTH-1:0] w_y;
    logic signed [GYRO_WIDTH-1:0] w_z;

    // Framing error status
    logic                         frame_err;
    logic                         frame_err_clr;

    modport master (
        output frame_start, byte_valid, byte_data, ready_out, frame_err_clr,
        input  byte_ready, valid_out, a_x, a_y, a_z, w_x, w_y, w_z, frame_err
    );

    modport slave (
        input  frame_start, byte_valid, byte_data, ready_out, frame_err_clr,
        output byte_ready, valid_out, a_x, a_y, a_z, w_x, w_y, w_z, frame_err
    );
endinterface

// File: rtl/imu_sample_packer.sv
// imu_sample_packer: assembles one IMU burst frame (accel XYZ, temperature
// skipped, gyro XYZ, big-endian 16-bit signed) and presents each axis scaled
// to filter width with round-half-up and saturation on a valid/ready port.
// Optional feature: define IMU_AXIS_INVERT_EN to add the axis_invert[5:0]
// port (bit0=a_x .. bit5=w_z) that negates selected scaled axes.
module imu_sample_packer #(
    parameter int ACC_WIDTH  = 11,
    parameter int GYRO_WIDTH = 14,
    parameter int ACC_SHIFT  = 5,
    parameter int GYRO_SHIFT = 2,
    parameter int TEMP_BYTES = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef IMU_AXIS_INVERT_EN
    input  logic [5:0] axis_invert,
`endif
    imu_sample_packer_if.slave bus
);

    localparam int FRAME_LEN  = 12 + TEMP_BYTES;
    localparam int IDX_W      = $clog2(FRAME_LEN);
    localparam int GYRO_FIRST = 6 + TEMP_BYTES;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] ACC_END    = IDX_W'(6);
    localparam logic [IDX_W-1:0] GYRO_START = IDX_W'(GYRO_FIRST);
    localparam logic [IDX_W-1:0] TEMP_SKIP  = IDX_W'(TEMP_BYTES);

    typedef enum logic {COLLECT, PENDING} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  eff_idx;
    logic [IDX_W-1:0]  slot;
    logic [7:0]        raw_bytes [12];
    logic              byte_ready;
    logic              xfer;
    logic              restart;
    logic              load;
    logic signed [16:0] scaled [6];

    // Round-half-up arithmetic shift of a 16-bit raw value, saturated to width bits.
    function automatic logic signed [16:0] scale(input logic [15:0] raw,
                                                 input int shift, input int width);
        logic signed [16:0] ext;
        logic signed [16:0] t;
        logic signed [16:0] hi;
        logic signed [16:0] lo;
        ext = {raw[15], raw};
        t   = (ext + (17'sd1 <<< (shift - 1))) >>> shift;
        hi  = (17'sd1 <<< (width - 1)) - 17'sd1;
        lo  = -(17'sd1 <<< (width - 1));
        if (t > hi)
            t = hi;
        else if (t < lo)
            t = lo;
        return t;
    endfunction

`ifdef IMU_AXIS_INVERT_EN
    // Negation that maps the most-negative code onto the most-positive one.
    function automatic logic signed [16:0] negate(input logic signed [16:0] v,
                                                  input int width);
        logic signed [16:0] hi;
        logic signed [16:0] lo;
        hi = (17'sd1 <<< (width - 1)) - 17'sd1;
        lo = -(17'sd1 <<< (width - 1));
        return (v == lo) ? hi : -v;
    endfunction
`endif

    // A frame_start on the accepting cycle makes the current byte byte 0.
    assign eff_idx        = bus.frame_start ? '0 : idx;
    assign slot           = eff_idx - TEMP_SKIP;
    assign xfer           = bus.byte_valid && byte_ready;
    assign restart        = (state == COLLECT) && bus.frame_start && (idx != '0);
    assign bus.byte_ready = byte_ready;

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_next;
    end

    // Next-state decode, byte acceptance and output-load strobe.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        load       = 1'b0;
        unique case (state)
            COLLECT: begin
                byte_ready = 1'b1;
                if (bus.byte_valid && eff_idx == LAST_IDX)
                    state_next = PENDING;
            end
            PENDING: begin
                if (!bus.valid_out || bus.ready_out) begin
                    load       = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Byte index: advances per accepted byte, restarts on frame_start or load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx <= '0;
        else if (load)
            idx <= '0;
        else if (xfer)
            idx <= eff_idx + 1'b1;
        else if (restart)
            idx <= '0;
    end

    // Assembly registers: accel bytes land in slots 0-5, gyro bytes in 6-11,
    // temperature bytes are dropped.
    // NOTE: this small byte store is reset like any other register because the
    // sample it feeds must read as zero after reset; it is not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 12; i++)
                raw_bytes[i] <= '0;
        end else if (xfer) begin
            if (eff_idx < ACC_END)
                raw_bytes[eff_idx] <= bus.byte_data;
            else if (eff_idx >= GYRO_START)
                raw_bytes[slot] <= bus.byte_data;
        end
    end

    // Scale (and optionally invert) all six axes from the assembly registers.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            if (k < 3)
                scaled[k] = scale({raw_bytes[2*k], raw_bytes[2*k+1]}, ACC_SHIFT, ACC_WIDTH);
            else
                scaled[k] = scale({raw_bytes[2*k], raw_bytes[2*k+1]}, GYRO_SHIFT, GYRO_WIDTH);
`ifdef IMU_AXIS_INVERT_EN
            if (axis_invert[k])
                scaled[k] = negate(scaled[k], (k < 3) ? ACC_WIDTH : GYRO_WIDTH);
`endif
        end
    end

    // Output register: loads from PENDING, holds under backpressure, clears on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_out <= 1'b0;
            bus.a_x       <= '0;
            bus.a_y       <= '0;
            bus.a_z       <= '0;
            bus.w_x       <= '0;
            bus.w_y       <= '0;
            bus.w_z       <= '0;
        end else if (load) begin
            bus.valid_out <= 1'b1;
            bus.a_x       <= scaled[0][ACC_WIDTH-1:0];
            bus.a_y       <= scaled[1][ACC_WIDTH-1:0];
            bus.a_z       <= scaled[2][ACC_WIDTH-1:0];
            bus.w_x       <= scaled[3][GYRO_WIDTH-1:0];
            bus.w_y       <= scaled[4][GYRO_WIDTH-1:0];
            bus.w_z       <= scaled[5][GYRO_WIDTH-1:0];
        end else if (bus.ready_out) begin
            bus.valid_out <= 1'b0;
        end
    end

    // Sticky framing error: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.frame_err <= 1'b0;
        else if (restart)
            bus.frame_err <= 1'b1;
        else if (bus.frame_err_clr)
            bus.frame_err <= 1'b0;
    end

endmodule

// File: tb/tb_imu_sample_packer.sv
// Self-checking bench for imu_sample_packer: a table of directed frames with
// hand-computed scaled values, plus sequences for backpressure, framing
// errors and reset in the middle of activity.
module tb_imu_sample_packer;

    localparam int ACC_WIDTH  = 11;
    localparam int GYRO_WIDTH = 14;
    localparam int TEMP_BYTES = 2;

    typedef struct {
        string            name;
        logic [5:0][15:0] raw;   // ax, ay, az, gx, gy, gz
        logic [5:0][31:0] exp;   // expected scaled values as 32-bit ints
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [4];

`ifdef IMU_AXIS_INVERT_EN
    logic [5:0] axis_invert = '0;
`endif

    imu_sample_packer_if #(.ACC_WIDTH(ACC_WIDTH), .GYRO_WIDTH(GYRO_WIDTH)) bus ();

    imu_sample_packer #(
        .ACC_WIDTH (ACC_WIDTH),
        .GYRO_WIDTH(GYRO_WIDTH),
        .ACC_SHIFT (5),
        .GYRO_SHIFT(2),
        .TEMP_BYTES(TEMP_BYTES)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef IMU_AXIS_INVERT_EN
        .axis_invert(axis_invert),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n,
                                input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az,
                                input logic [15:0] gx, input logic [15:0] gy, input logic [15:0] gz,
                                input int eax, input int eay, input int eaz,
                                input int egx, input int egy, input int egz);
        vec_t v;
        v.name   = n;
        v.raw[0] = ax;  v.raw[1] = ay;  v.raw[2] = az;
        v.raw[3] = gx;  v.raw[4] = gy;  v.raw[5] = gz;
        v.exp[0] = eax; v.exp[1] = eay; v.exp[2] = eaz;
        v.exp[3] = egx; v.exp[4] = egy; v.exp[5] = egz;
        return v;
    endfunction

    // Offer one byte and hold it until it is accepted (bounded wait).
    task automatic send_byte(input logic [7:0] d, input logic fs);
        int waited = 0;
        bus.byte_valid  = 1'b1;
        bus.byte_data   = d;
        bus.frame_start = fs;
        while (!bus.byte_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.byte_ready)
            check("byte_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.byte_valid  = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0][15:0] raw, input logic fs_first);
        for (int k = 0; k < 3; k++) begin
            send_byte(raw[k][15:8], fs_first && (k == 0));
            send_byte(raw[k][7:0], 1'b0);
        end
        for (int t = 0; t < TEMP_BYTES; t++)
            send_byte(8'hAA, 1'b0);
        for (int k = 3; k < 6; k++) begin
            send_byte(raw[k][15:8], 1'b0);
            send_byte(raw[k][7:0], 1'b0);
        end
    endtask

    task automatic check_sample(input vec_t v);
        check({v.name, "_ax"}, int'(bus.a_x), int'(v.exp[0]));
        check({v.name, "_ay"}, int'(bus.a_y), int'(v.exp[1]));
        check({v.name, "_az"}, int'(bus.a_z), int'(v.exp[2]));
        check({v.name, "_wx"}, int'(bus.w_x), int'(v.exp[3]));
        check({v.name, "_wy"}, int'(bus.w_y), int'(v.exp[4]));
        check({v.name, "_wz"}, int'(bus.w_z), int'(v.exp[5]));
    endtask

    // Full frame with ready_out=1: valid_out rises one cycle after the last
    // byte, carries the expected sample, then clears on the handshake.
    task automatic run_vec(input vec_t v, input logic fs);
        send_frame(v.raw, fs);
        check({v.name, "_valid_early"}, int'(bus.valid_out), 0);
        @(posedge clk); #1;
        check({v.name, "_valid"}, int'(bus.valid_out), 1);
        check_sample(v);
        @(posedge clk); #1;
        check({v.name, "_valid_clear"}, int'(bus.valid_out), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk("nominal", 16'hFEE0, 16'h0520, 16'h0310, 16'hF1FC, 16'h0171, 16'hF550,
                     -9, 41, 25, -897, 92, -684);
        vecs[1] = mk("saturate", 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF,
                     1023, -1024, 0, -8192, 8191, 0);
        vecs[2] = mk("rounding", 16'h0010, 16'h000F, 16'hFFF0, 16'hFFFE, 16'h0002, 16'hFFFD,
                     1, 0, 0, 0, 1, -1);
        vecs[3] = mk("midrange", 16'h1000, 16'hF000, 16'h4000, 16'h1000, 16'hE000, 16'h7000,
                     128, -128, 512, 1024, -2048, 7168);

        bus.frame_start   = 1'b0;
        bus.byte_valid    = 1'b0;
        bus.byte_data     = '0;
        bus.ready_out     = 1'b1;
        bus.frame_err_clr = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", int'(bus.valid_out), 0);
        check("rst_byte_ready", int'(bus.byte_ready), 1);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_ax", int'(bus.a_x), 0);
        check("rst_wz", int'(bus.w_z), 0);

        // Table-driven frames; vector 2 also pulses frame_start at index 0
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], i == 2);
            check({vecs[i].name, "_no_err"}, int'(bus.frame_err), 0);
        end

        // Backpressure: second frame completes while the first is still held
        bus.ready_out = 1'b0;
        send_frame(vecs[0].raw, 1'b0);
        @(posedge clk); #1;
        check("bp_first_valid", int'(bus.valid_out), 1);
        send_frame(vecs[3].raw, 1'b0);
        check("bp_stall_ready", int'(bus.byte_ready), 0);
        check("bp_hold_valid", int'(bus.valid_out), 1);
        check("bp_hold_ax", int'(bus.a_x), -9);
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        check("bp_pending_fs_no_err", int'(bus.frame_err), 0);
        check("bp_hold_wz", int'(bus.w_z), -684);
        check("bp_still_stalled", int'(bus.byte_ready), 0);
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        check("bp_reload_valid", int'(bus.valid_out), 1);
        check_sample(vecs[3]);
        check("bp_ready_back", int'(bus.byte_ready), 1);
        @(posedge clk); #1;
        check("bp_drained", int'(bus.valid_out), 0);

        // frame_start after 5 bytes: partial frame dropped, error latched
        for (int i = 0; i < 5; i++)
            send_byte(8'h55, 1'b0);
        check("ferr_before", int'(bus.frame_err), 0);
        run_vec(vecs[1], 1'b1);
        check("ferr_set", int'(bus.frame_err), 1);
        bus.frame_err_clr = 1'b1;
        @(posedge clk); #1;
        bus.frame_err_clr = 1'b0;
        check("ferr_cleared", int'(bus.frame_err), 0);

        // Set and clear in the same cycle: set wins, index restarts
        for (int i = 0; i < 3; i++)
            send_byte(8'h33, 1'b0);
        bus.frame_start   = 1'b1;
        bus.frame_err_clr = 1'b1;
        @(posedge clk); #1;
        bus.frame_start   = 1'b0;
        bus.frame_err_clr = 1'b0;
        check("ferr_set_wins", int'(bus.frame_err), 1);
        bus.frame_err_clr = 1'b1;
        @(posedge clk); #1;
        bus.frame_err_clr = 1'b0;
        check("ferr_cleared2", int'(bus.frame_err), 0);
        run_vec(vecs[2], 1'b0);

        // Reset with a held sample and a partial frame in flight
        bus.ready_out = 1'b0;
        send_frame(vecs[0].raw, 1'b0);
        @(posedge clk); #1;
        check("mid_rst_valid_before", int'(bus.valid_out), 1);
        for (int i = 0; i < 4; i++)
            send_byte(8'h77, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.valid_out), 0);
        check("mid_rst_ax", int'(bus.a_x), 0);
        check("mid_rst_ay", int'(bus.a_y), 0);
        check("mid_rst_wx", int'(bus.w_x), 0);
        check("mid_rst_wz", int'(bus.w_z), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[3], 1'b0);

`ifdef IMU_AXIS_INVERT_EN
        // Inverting the most-negative accel code yields the most-positive one
        axis_invert = 6'b000001;
        run_vec(mk("invert", 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   1023, 0, 0, 0, 0, 0), 1'b0);
        axis_invert = 6'b000000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imu_sample_packer.md
Name: imu_sample_packer

Overview:
Upstream feeder for the madgwick filter. Takes the raw byte stream from the IMU SPI burst-read engine and assembles one 14-byte frame: accel X/Y/Z, temperature (skipped), gyro X/Y/Z, each big-endian 16-bit signed. Each axis is scaled to filter width with round-half-up and saturation. The result is presented on the filter's valid/ready input handshake (a_x..w_z).

Parameters:
ACC_WIDTH, 11, output accel width (signed); matches filter input.
GYRO_WIDTH, 14, output gyro width (signed); matches filter input.
ACC_SHIFT, 5, arithmetic right shift applied to raw accel (≥1).
GYRO_SHIFT, 2, arithmetic right shift applied to raw gyro (≥1).
TEMP_BYTES, 2, bytes discarded between accel Z and gyro X (0 allowed).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_start  in  1  pulse; next accepted byte is byte 0 of a frame
byte_valid  in  1  byte_data valid
byte_ready  out  1  packer accepts byte this cycle
byte_data  in  8  raw IMU byte
valid_out  out  1  scaled sample available (drives filter valid_in)
ready_out  in  1  filter ready_in
a_x, a_y, a_z  out  ACC_WIDTH each  scaled accel, signed
w_x, w_y, w_z  out  GYRO_WIDTH each  scaled gyro, signed
frame_err  out  1  sticky: frame_start seen mid-frame
frame_err_clr  in  1  clears frame_err

Behaviour:
- Reset (async, rst=1): byte index 0, state COLLECT, all assembly registers 0, valid_out=0, all sample outputs 0, frame_err=0, byte_ready=1 after release.
- Frame length: L = 12 + TEMP_BYTES. A byte transfers when byte_valid && byte_ready. Index order: AXH, AXL, AYH, AYL, AZH, AZL, TEMP_BYTES discarded, GXH, GXL, GYH, GYL, GZH, GZL.
- States:
  - COLLECT: byte_ready=1. Index increments per transfer. On transfer at index L-1, go to PENDING.
  - PENDING: byte_ready=0. When the output register is empty, or emptying this cycle (valid_out && ready_out), load scaled values, set valid_out, reset index to 0, return to COLLECT.
- Latency: last byte accepted at edge N → valid_out=1 after edge N+1 if output free. Back-to-back transfer allowed in the same cycle as the output handshake, with no bubble.
- Output handshake: outputs hold stable while valid_out && !ready_out. valid_out clears on handshake unless reloaded the same cycle.
- Scaling per axis: r = 16-bit signed raw. t = (17-bit sign-extended r + 2^(SHIFT-1)) >>> SHIFT. Saturate t to [-2^(W-1), 2^(W-1)-1].
- frame_start:
  - In COLLECT with index 0: no effect.
  - In COLLECT with index >0: partial frame dropped, index forced 0, frame_err=1.
  - In PENDING: ignored (frame complete).
  - frame_start coincident with a byte transfer: that byte becomes byte 0.
- frame_err_clr: clears frame_err. If set and clear occur in the same cycle, set wins.
- Reset mid-frame or with valid_out high: everything returns to reset values immediately; pending sample lost.

Optional Feature:
Macro IMU_AXIS_INVERT_EN. When defined, adds input port axis_invert [5:0] (bit0=a_x … bit5=w_z). A set bit negates the scaled, saturated value before the output register. The most-negative value negates to the most-positive (e.g. -1024 → 1023). When not defined, the port is absent and values pass unchanged.

Test Plan:
- Frame AX=0xFEE0, AY=0x0520, AZ=0x0310, TEMP=0xAAAA, GX=0xF1FC, GY=0x0171, GZ=0xF550, ready_out=1 → a_x=-9 (0x7F7), a_y=41, a_z=25 (0x310=784; 800>>>5=25), w_x=-897, w_y=92, w_z=-684, valid_out 1 cycle after last byte.
- Saturation: AX=0x7FFF, GX=0x8000 → a_x=1023, w_x=-8192. Rounding: GX=0xFFFF → w_x=0.
- Backpressure: ready_out=0 while a second frame completes → byte_ready=0 after byte L-1, first sample held stable. Raise ready_out → second sample loads the same cycle, valid_out stays 1, byte_ready returns 1.
- frame_start after 5 bytes → frame_err=1, next 14 bytes form a correct frame. Pulse frame_err_clr → frame_err=0.
- Assert rst with valid_out=1 and mid-frame → all outputs 0 same cycle; a clean frame afterwards is correct.
- IMU_AXIS_INVERT_EN, axis_invert=6'b000001, AX=0x8000 → a_x=1023.
